aux_cmd_engine: RTL and testbench

- Command initiator on the far side of the aux_io control interface.
- Pulls 32-bit command words from the host via aux_io reads, executes them against a local register bus, and pushes response words back via aux_io writes.
- Provides host-driven register access on the CalPC fabric clock. Sits between aux_io and the configuration register file.

---
 rtl/aux_cmd_engine_if.sv | 23 ++
 rtl/aux_cmd_engine.sv | 152 +++++++++++++++
 tb/tb_aux_cmd_engine.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aux_cmd_engine_if.sv
// aux_io control link between the command engine (master) and aux_io (slave).
// Handshake: master pulses a read/write req for one cycle only while busy=0;
// slave raises busy the next cycle and drops it when the transfer completes.
// Read data is valid in the first cycle busy is low again; write data is held by the master.
interface aux_cmd_engine_if;
    logic        aux_read_req;
    logic        aux_write_req;
    logic [31:0] aux_data_write;
    logic [31:0] aux_data_read;
    logic [16:0] aux_address;
    logic        aux_busy;
    logic [3:0]  dbg_state;

    modport master (
        output aux_read_req, aux_write_req, aux_data_write, aux_address, dbg_state,
        input  aux_data_read, aux_busy
    );

    modport slave (
        input  aux_read_req, aux_write_req, aux_data_write, aux_address, dbg_state,
        output aux_data_read, aux_busy
    );
endinterface

// File: rtl/aux_cmd_engine.sv
// Command engine: fetches headers/payloads over aux_io, executes WRITE/READ/NOP
// against the local register bus and returns one response word per command or read word.
module aux_cmd_engine #(
    parameter int MAX_COUNT = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    aux_cmd_engine_if.master        aux,
    output logic [15:0]             reg_addr,
    output logic [31:0]             reg_wdata,
    output logic                    reg_we,
    output logic                    reg_re,
    input  logic [31:0]             reg_rdata,
    output logic                    active,
    output logic [15:0]             cmd_done_count,
    output logic [15:0]             cmd_err_count
);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        HDR_REQ    = 4'd1,
        HDR_WAIT   = 4'd2,
        DECODE     = 4'd3,
        WD_REQ     = 4'd4,
        WD_WAIT    = 4'd5,
        REG_WR     = 4'd6,
        RD_STROBE  = 4'd7,
        RD_CAPTURE = 4'd8,
        RSP_REQ    = 4'd9,
        RSP_WAIT   = 4'd10,
        NEXT       = 4'd11
    } state_t;

    localparam logic [11:0] MAX_CNT  = 12'(MAX_COUNT);
    localparam logic [3:0]  OP_NOP   = 4'd0;
    localparam logic [3:0]  OP_WRITE = 4'd1;
    localparam logic [3:0]  OP_READ  = 4'd2;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] hdr;
    logic [31:0] wdata;
    logic [31:0] rsp;
    logic [15:0] addr;
    logic [11:0] cnt;
    logic [15:0] done_cnt;
    logic [15:0] err_cnt;

    logic [3:0]  hdr_op;
    logic [11:0] hdr_cnt;
    logic        hdr_err;

    assign hdr_op  = hdr[31:28];
    assign hdr_cnt = hdr[27:16];
    assign hdr_err = (hdr_op > OP_READ) ||
                     ((hdr_op != OP_NOP) && ((hdr_cnt == 12'd0) || (hdr_cnt > MAX_CNT)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (enable && !aux.aux_busy) state_nxt = HDR_REQ;
            HDR_REQ:    if (!aux.aux_busy) state_nxt = HDR_WAIT;
            HDR_WAIT:   if (!aux.aux_busy) state_nxt = DECODE;
            DECODE:     state_nxt = (hdr_err || hdr_op != OP_WRITE) ? RSP_REQ : WD_REQ;
            WD_REQ:     if (!aux.aux_busy) state_nxt = WD_WAIT;
            WD_WAIT:    if (!aux.aux_busy) state_nxt = REG_WR;
            REG_WR:     state_nxt = (cnt == 12'd1) ? RSP_REQ : WD_REQ;
            RD_STROBE:  state_nxt = RD_CAPTURE;
            RD_CAPTURE: state_nxt = RSP_REQ;
            RSP_REQ:    if (!aux.aux_busy) state_nxt = RSP_WAIT;
            // Words still owed means a READ is mid-transfer; otherwise the command is finished.
            RSP_WAIT:   if (!aux.aux_busy) state_nxt = (cnt != 12'd0) ? RD_STROBE : NEXT;
            NEXT:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        aux.aux_read_req  = 1'b0;
        aux.aux_write_req = 1'b0;
        reg_we            = 1'b0;
        reg_re            = 1'b0;
        case (state)
            HDR_REQ, WD_REQ: aux.aux_read_req  = !aux.aux_busy;
            RSP_REQ:         aux.aux_write_req = !aux.aux_busy;
            REG_WR:          reg_we = 1'b1;
            RD_STROBE:       reg_re = 1'b1;
            default: ;
        endcase
        active = (state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hdr      <= '0;
            wdata    <= '0;
            rsp      <= '0;
            addr     <= '0;
            cnt      <= '0;
            done_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            case (state)
                HDR_WAIT: if (!aux.aux_busy) hdr <= aux.aux_data_read;
                DECODE: begin
                    addr <= hdr[15:0];
                    // Errors and NOPs carry no data words, so the counter starts empty.
                    cnt  <= (hdr_err || hdr_op == OP_NOP) ? 12'd0 : hdr_cnt;
                    if (hdr_err) begin
                        rsp     <= {4'hE, hdr[27:0]};
                        err_cnt <= err_cnt + 16'd1;
                    end else if (hdr_op == OP_NOP) begin
                        rsp <= {4'h8, hdr[27:0]};
                    end else if (hdr_op == OP_READ) begin
                        rsp <= {4'hA, hdr[27:0]};
                    end
                end
                WD_WAIT: if (!aux.aux_busy) wdata <= aux.aux_data_read;
                REG_WR: begin
                    addr <= addr + 16'd1;
                    cnt  <= cnt - 12'd1;
                    if (cnt == 12'd1) rsp <= {4'h9, hdr[27:0]};
                end
                RD_CAPTURE: begin
                    rsp  <= reg_rdata;
                    addr <= addr + 16'd1;
                    cnt  <= cnt - 12'd1;
                end
                NEXT: done_cnt <= done_cnt + 16'd1;
                default: ;
            endcase
        end
    end

    assign aux.aux_data_write = rsp;
    assign aux.aux_address    = 17'd0;
    assign aux.dbg_state      = state;
    assign reg_addr           = addr;
    assign reg_wdata          = wdata;
    assign cmd_done_count     = done_cnt;
    assign cmd_err_count      = err_cnt;

endmodule

// File: tb/tb_aux_cmd_engine.sv
// Bench for aux_cmd_engine: aux_io and register-file models, observation logs,
// and scenario tasks that compare logged traffic against expected queues.
module tb_aux_cmd_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [31:0] reg_rdata;
    logic        active;
    logic [15:0] cmd_done_count;
    logic [15:0] cmd_err_count;

    aux_cmd_engine_if aux();

    aux_cmd_engine #(.MAX_COUNT(256)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .aux            (aux),
        .reg_addr       (reg_addr),
        .reg_wdata      (reg_wdata),
        .reg_we         (reg_we),
        .reg_re         (reg_re),
        .reg_rdata      (reg_rdata),
        .active         (active),
        .cmd_done_count (cmd_done_count),
        .cmd_err_count  (cmd_err_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int busy_lat = 1;

    // aux_io model: words queued by the tasks are served one per read request.
    logic [31:0] feed_mem [256];
    int          feed_wr = 0;
    int          feed_rd;
    int          busy_left;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_left         <= 0;
            feed_rd           <= feed_wr;
            aux.aux_data_read <= '0;
        end else begin
            if (aux.aux_read_req || aux.aux_write_req) busy_left <= busy_lat;
            else if (busy_left > 0) busy_left <= busy_left - 1;
            if (aux.aux_read_req) begin
                if (feed_rd < feed_wr) begin
                    aux.aux_data_read <= feed_mem[feed_rd[7:0]];
                    feed_rd <= feed_rd + 1;
                end else begin
                    aux.aux_data_read <= 32'hDEAD_BEEF;
                end
            end
        end
    end
    assign aux.aux_busy = (busy_left != 0);

    // Register file model: returns address + 0x100 one cycle after reg_re.
    always @(posedge clk or posedge reset) begin
        if (reset) reg_rdata <= '0;
        else if (reg_re) reg_rdata <= {16'h0, reg_addr} + 32'h100;
    end

    // Observation logs and protocol watchers.
    logic [31:0] obs_rsp [256];
    logic [47:0] obs_wr  [256];
    logic [15:0] obs_rd  [256];
    int obs_rsp_n = 0;
    int obs_wr_n  = 0;
    int obs_rd_n  = 0;
    int rd_req_n  = 0;
    int wr_req_n  = 0;
    int viol_both_req = 0;
    int viol_both_stb = 0;
    int viol_req_busy = 0;
    int viol_stable   = 0;
    int viol_early    = 0;
    logic        pend;
    logic        pend_w;
    logic [31:0] held;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pend   <= 1'b0;
            pend_w <= 1'b0;
        end else begin
            if (aux.aux_read_req && aux.aux_write_req) viol_both_req <= viol_both_req + 1;
            if (reg_we && reg_re) viol_both_stb <= viol_both_stb + 1;
            if (reg_we) begin
                obs_wr[obs_wr_n[7:0]] <= {reg_addr, reg_wdata};
                obs_wr_n <= obs_wr_n + 1;
            end
            if (reg_re) begin
                obs_rd[obs_rd_n[7:0]] <= reg_addr;
                obs_rd_n <= obs_rd_n + 1;
            end
            if (aux.aux_read_req || aux.aux_write_req) begin
                if (aux.aux_busy || pend) viol_req_busy <= viol_req_busy + 1;
                pend   <= 1'b1;
                pend_w <= aux.aux_write_req;
                held   <= aux.aux_data_write;
                if (aux.aux_write_req) begin
                    obs_rsp[obs_rsp_n[7:0]] <= aux.aux_data_write;
                    obs_rsp_n <= obs_rsp_n + 1;
                    wr_req_n  <= wr_req_n + 1;
                end else begin
                    rd_req_n <= rd_req_n + 1;
                end
            end else if (pend) begin
                if (pend_w && aux.aux_data_write !== held) viol_stable <= viol_stable + 1;
                if (!(aux.dbg_state inside {4'd2, 4'd5, 4'd10})) viol_early <= viol_early + 1;
                if (!aux.aux_busy) pend <= 1'b0;
            end
        end
    end

    function automatic int viol_sum();
        return viol_both_req + viol_both_stb + viol_req_busy + viol_stable + viol_early;
    endfunction

    logic [31:0] exp_rsp_q [$];
    logic [47:0] exp_wr_q  [$];
    logic [15:0] exp_rd_q  [$];

    task automatic push_feed(input logic [31:0] w);
        feed_mem[feed_wr[7:0]] = w;
        feed_wr++;
    endtask

    // Runs queued commands: enable until the engine goes active, then wait for idle.
    task automatic issue(output bit ok);
        int n;
        ok = 1'b1;
        enable = 1'b1;
        n = 0;
        while (!active && n < 50) begin @(negedge clk); n++; end
        if (!active) ok = 1'b0;
        enable = 1'b0;
        n = 0;
        while (active && n < 5000) begin @(negedge clk); n++; end
        if (active) ok = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        #12;
        total++;
        if ({aux.aux_read_req, aux.aux_write_req, reg_we, reg_re, active} !== 5'b0) begin
            bad++; $display("FAIL reset_strobes: got %b want 00000",
                {aux.aux_read_req, aux.aux_write_req, reg_we, reg_re, active});
        end
        total++;
        if ({aux.aux_data_write, reg_addr, reg_wdata, aux.aux_address} !== 97'd0) begin
            bad++; $display("FAIL reset_data: got %h/%h/%h/%h want 0", aux.aux_data_write,
                reg_addr, reg_wdata, aux.aux_address);
        end
        total++;
        if ({cmd_done_count, cmd_err_count} !== 32'd0) begin
            bad++; $display("FAIL reset_counts: got %h/%h want 0/0", cmd_done_count, cmd_err_count);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (active !== 1'b0) begin
            bad++; $display("FAIL idle_without_enable: active got %b want 0", active);
        end
    endtask

    task automatic test_write();
        int b_rsp = obs_rsp_n, b_wr = obs_wr_n, b_rd = rd_req_n;
        bit ok;
        logic [31:0] e;
        logic [47:0] ew;
        push_feed(32'h1003_0010);
        push_feed(32'hA); push_feed(32'hB); push_feed(32'hC);
        exp_wr_q.push_back({16'h0010, 32'hA});
        exp_wr_q.push_back({16'h0011, 32'hB});
        exp_wr_q.push_back({16'h0012, 32'hC});
        exp_rsp_q.push_back(32'h9003_0010);
        issue(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL write_timeout: active got %b want 0", active); end
        while (exp_wr_q.size() > 0) begin
            ew = exp_wr_q.pop_front();
            total++;
            if (b_wr >= obs_wr_n || obs_wr[b_wr[7:0]] !== ew) begin
                bad++; $display("FAIL write_regwr: got %h want %h", obs_wr[b_wr[7:0]], ew);
            end
            b_wr++;
        end
        while (exp_rsp_q.size() > 0) begin
            e = exp_rsp_q.pop_front();
            total++;
            if (b_rsp >= obs_rsp_n || obs_rsp[b_rsp[7:0]] !== e) begin
                bad++; $display("FAIL write_rsp: got %h want %h", obs_rsp[b_rsp[7:0]], e);
            end
            b_rsp++;
        end
        total++;
        if (obs_wr_n !== b_wr || obs_rsp_n !== b_rsp || rd_req_n - b_rd !== 4) begin
            bad++; $display("FAIL write_traffic: wr=%0d rsp=%0d reads=%0d want %0d/%0d/4",
                obs_wr_n, obs_rsp_n, rd_req_n - b_rd, b_wr, b_rsp);
        end
        total++;
        if (cmd_done_count !== 16'd1 || cmd_err_count !== 16'd0) begin
            bad++; $display("FAIL write_counts: got %0d/%0d want 1/0", cmd_done_count, cmd_err_count);
        end
    endtask

    task automatic test_read_wrap();
        int b_rsp = obs_rsp_n, b_rd = obs_rd_n, b_req = rd_req_n, b_wr = obs_wr_n;
        bit ok;
        logic [31:0] e;
        logic [15:0] ea;
        push_feed(32'h2002_FFFF);
        exp_rsp_q.push_back(32'hA002_FFFF);
        exp_rsp_q.push_back(32'h0001_00FF);
        exp_rsp_q.push_back(32'h0000_0100);
        exp_rd_q.push_back(16'hFFFF);
        exp_rd_q.push_back(16'h0000);
        issue(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL read_timeout: active got %b want 0", active); end
        while (exp_rsp_q.size() > 0) begin
            e = exp_rsp_q.pop_front();
            total++;
            if (b_rsp >= obs_rsp_n || obs_rsp[b_rsp[7:0]] !== e) begin
                bad++; $display("FAIL read_rsp: got %h want %h", obs_rsp[b_rsp[7:0]], e);
            end
            b_rsp++;
        end
        while (exp_rd_q.size() > 0) begin
            ea = exp_rd_q.pop_front();
            total++;
            if (b_rd >= obs_rd_n || obs_rd[b_rd[7:0]] !== ea) begin
                bad++; $display("FAIL read_addr: got %h want %h", obs_rd[b_rd[7:0]], ea);
            end
            b_rd++;
        end
        total++;
        if (obs_rsp_n !== b_rsp || obs_rd_n !== b_rd || obs_wr_n !== b_wr || rd_req_n - b_req !== 1) begin
            bad++; $display("FAIL read_traffic: rsp=%0d re=%0d we=%0d reads=%0d want %0d/%0d/%0d/1",
                obs_rsp_n, obs_rd_n, obs_wr_n, rd_req_n - b_req, b_rsp, b_rd, b_wr);
        end
        total++;
        if (cmd_done_count !== 16'd2 || cmd_err_count !== 16'd0) begin
            bad++; $display("FAIL read_counts: got %0d/%0d want 2/0", cmd_done_count, cmd_err_count);
        end
    endtask

    task automatic test_bad_opcode();
        int b_rsp = obs_rsp_n, b_wr = obs_wr_n, b_rd = obs_rd_n, b_req = rd_req_n;
        bit ok;
        logic [31:0] e;
        push_feed(32'h5001_0000);
        push_feed(32'h1234_5678);
        exp_rsp_q.push_back(32'hE001_0000);
        issue(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL opcode_timeout: active got %b want 0", active); end
        e = exp_rsp_q.pop_front();
        total++;
        if (obs_rsp_n - b_rsp !== 1 || obs_rsp[b_rsp[7:0]] !== e) begin
            bad++; $display("FAIL opcode_rsp: got %h (n=%0d) want %h (n=1)",
                obs_rsp[b_rsp[7:0]], obs_rsp_n - b_rsp, e);
        end
        total++;
        if (obs_wr_n !== b_wr || obs_rd_n !== b_rd || rd_req_n - b_req !== 1) begin
            bad++; $display("FAIL opcode_traffic: we=%0d re=%0d reads=%0d want 0/0/1",
                obs_wr_n - b_wr, obs_rd_n - b_rd, rd_req_n - b_req);
        end
        total++;
        if (cmd_done_count !== 16'd3 || cmd_err_count !== 16'd1) begin
            bad++; $display("FAIL opcode_counts: got %0d/%0d want 3/1", cmd_done_count, cmd_err_count);
        end
        feed_wr = feed_rd;
    endtask

    task automatic test_bad_count();
        int b_rsp = obs_rsp_n, b_wr = obs_wr_n, b_rd = obs_rd_n, b_req = rd_req_n;
        bit ok0, ok1;
        logic [31:0] e;
        push_feed(32'h1000_0020);
        exp_rsp_q.push_back(32'hE000_0020);
        issue(ok0);
        push_feed(32'h1101_0000);
        exp_rsp_q.push_back(32'hE101_0000);
        issue(ok1);
        total++;
        if (!(ok0 && ok1)) begin bad++; $display("FAIL count_timeout: ok got %b%b want 11", ok0, ok1); end
        while (exp_rsp_q.size() > 0) begin
            e = exp_rsp_q.pop_front();
            total++;
            if (b_rsp >= obs_rsp_n || obs_rsp[b_rsp[7:0]] !== e) begin
                bad++; $display("FAIL count_rsp: got %h want %h", obs_rsp[b_rsp[7:0]], e);
            end
            b_rsp++;
        end
        total++;
        if (obs_wr_n !== b_wr || obs_rd_n !== b_rd || rd_req_n - b_req !== 2) begin
            bad++; $display("FAIL count_traffic: we=%0d re=%0d reads=%0d want 0/0/2",
                obs_wr_n - b_wr, obs_rd_n - b_rd, rd_req_n - b_req);
        end
        total++;
        if (cmd_done_count !== 16'd5 || cmd_err_count !== 16'd3) begin
            bad++; $display("FAIL count_counts: got %0d/%0d want 5/3", cmd_done_count, cmd_err_count);
        end
    endtask

    task automatic test_slow_bus();
        int b_rsp = obs_rsp_n, b_wr = obs_wr_n, b_rd = obs_rd_n, b_rq = rd_req_n, b_wq = wr_req_n;
        bit ok0, ok1;
        logic [15:0] a1 = 16'($urandom_range(0, 65535));
        logic [15:0] a2 = 16'($urandom_range(0, 65535));
        logic [31:0] d0 = $urandom;
        logic [31:0] d1 = $urandom;
        logic [31:0] e;
        logic [47:0] ew;
        logic [15:0] ea;
        busy_lat = 20;
        push_feed({4'h1, 12'd2, a1}); push_feed(d0); push_feed(d1);
        exp_wr_q.push_back({a1, d0});
        exp_wr_q.push_back({a1 + 16'd1, d1});
        exp_rsp_q.push_back({4'h9, 12'd2, a1});
        issue(ok0);
        push_feed({4'h2, 12'd1, a2});
        exp_rsp_q.push_back({4'hA, 12'd1, a2});
        exp_rsp_q.push_back({16'h0, a2} + 32'h100);
        exp_rd_q.push_back(a2);
        issue(ok1);
        busy_lat = 1;
        total++;
        if (!(ok0 && ok1)) begin bad++; $display("FAIL slow_timeout: ok got %b%b want 11", ok0, ok1); end
        while (exp_wr_q.size() > 0) begin
            ew = exp_wr_q.pop_front();
            total++;
            if (b_wr >= obs_wr_n || obs_wr[b_wr[7:0]] !== ew) begin
                bad++; $display("FAIL slow_regwr: got %h want %h", obs_wr[b_wr[7:0]], ew);
            end
            b_wr++;
        end
        while (exp_rd_q.size() > 0) begin
            ea = exp_rd_q.pop_front();
            total++;
            if (b_rd >= obs_rd_n || obs_rd[b_rd[7:0]] !== ea) begin
                bad++; $display("FAIL slow_readaddr: got %h want %h", obs_rd[b_rd[7:0]], ea);
            end
            b_rd++;
        end
        while (exp_rsp_q.size() > 0) begin
            e = exp_rsp_q.pop_front();
            total++;
            if (b_rsp >= obs_rsp_n || obs_rsp[b_rsp[7:0]] !== e) begin
                bad++; $display("FAIL slow_rsp: got %h want %h", obs_rsp[b_rsp[7:0]], e);
            end
            b_rsp++;
        end
        total++;
        if (rd_req_n - b_rq !== 4 || wr_req_n - b_wq !== 3) begin
            bad++; $display("FAIL slow_req_pulses: reads=%0d writes=%0d want 4/3",
                rd_req_n - b_rq, wr_req_n - b_wq);
        end
        total++;
        if (viol_sum() !== 0) begin
            bad++; $display("FAIL protocol: both_req=%0d both_stb=%0d req_busy=%0d unstable=%0d early=%0d want 0",
                viol_both_req, viol_both_stb, viol_req_busy, viol_stable, viol_early);
        end
        total++;
        if (cmd_done_count !== 16'd7 || cmd_err_count !== 16'd3) begin
            bad++; $display("FAIL slow_counts: got %0d/%0d want 7/3", cmd_done_count, cmd_err_count);
        end
    endtask

    task automatic test_reset_mid();
        int b_wr = obs_wr_n, b_rsp;
        int n = 0;
        bit ok;
        logic [31:0] e;
        logic [47:0] ew;
        logic [31:0] p [4];
        for (int i = 0; i < 4; i++) p[i] = $urandom;
        push_feed(32'h1004_0040);
        for (int i = 0; i < 4; i++) push_feed(p[i]);
        exp_wr_q.push_back({16'h0040, p[0]});
        exp_wr_q.push_back({16'h0041, p[1]});
        enable = 1'b1;
        while (!active && n < 50) begin @(negedge clk); n++; end
        enable = 1'b0;
        n = 0;
        while (obs_wr_n - b_wr < 2 && n < 2000) begin @(negedge clk); n++; end
        total++;
        if (obs_wr_n - b_wr < 2) begin bad++; $display("FAIL midreset_timeout: writes got %0d want 2", obs_wr_n - b_wr); end
        while (exp_wr_q.size() > 0) begin
            ew = exp_wr_q.pop_front();
            total++;
            if (b_wr >= obs_wr_n || obs_wr[b_wr[7:0]] !== ew) begin
                bad++; $display("FAIL midreset_regwr: got %h want %h", obs_wr[b_wr[7:0]], ew);
            end
            b_wr++;
        end
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        total++;
        if ({aux.aux_read_req, aux.aux_write_req, reg_we, reg_re, active} !== 5'b0 ||
            {aux.aux_data_write, reg_addr, reg_wdata} !== 80'd0 ||
            {cmd_done_count, cmd_err_count} !== 32'd0) begin
            bad++; $display("FAIL midreset_outputs: got ctl=%b data=%h addr=%h wdata=%h cnt=%0d/%0d want all 0",
                {aux.aux_read_req, aux.aux_write_req, reg_we, reg_re, active},
                aux.aux_data_write, reg_addr, reg_wdata, cmd_done_count, cmd_err_count);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (obs_wr_n !== b_wr || active !== 1'b0) begin
            bad++; $display("FAIL midreset_abandon: extra writes %0d active %b want 0/0", obs_wr_n - b_wr, active);
        end
        b_rsp = obs_rsp_n;
        push_feed(32'h0000_1234);
        exp_rsp_q.push_back(32'h8000_1234);
        issue(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL nop_timeout: active got %b want 0", active); end
        e = exp_rsp_q.pop_front();
        total++;
        if (obs_rsp_n - b_rsp !== 1 || obs_rsp[b_rsp[7:0]] !== e) begin
            bad++; $display("FAIL nop_rsp: got %h (n=%0d) want %h (n=1)", obs_rsp[b_rsp[7:0]], obs_rsp_n - b_rsp, e);
        end
        total++;
        if (cmd_done_count !== 16'd1 || cmd_err_count !== 16'd0 || obs_wr_n !== b_wr) begin
            bad++; $display("FAIL nop_counts: got %0d/%0d extra writes %0d want 1/0/0",
                cmd_done_count, cmd_err_count, obs_wr_n - b_wr);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time got %0t want finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write();
        test_read_wrap();
        test_bad_opcode();
        test_bad_count();
        test_slow_bus();
        test_reset_mid();
        total++;
        if (viol_sum() !== 0) begin
            bad++; $display("FAIL protocol_final: both_req=%0d both_stb=%0d req_busy=%0d unstable=%0d early=%0d want 0",
                viol_both_req, viol_both_stb, viol_req_busy, viol_stable, viol_early);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
